// File: rtl/tt_dfd_capture_arb.sv
// tt_dfd_capture_arb: round-robin arbiter feeding a single shared debug capture
// register, drained by a valid/ready consumer. Each held entry is tagged with
// its source id, and back-pressure duration is reported in a saturating counter.
// Optional feature macro: TT_DFD_CAPTURE_ARB_PRIO0_EN (requester 0 high
// priority, with a bounded burst before one forced round-robin grant).
module tt_dfd_capture_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int STALL_W     = 16,
  parameter int PRIO0_BURST = 4,
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_rdy,
  output logic                      out_vld,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_rdy,
  output logic [STALL_W-1:0]        stall_cnt,
  output logic                      busy
);

  // Reject illegal configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > 16 || PRIO0_BURST < 1) begin : g_bad_param
    $error("tt_dfd_capture_arb: NUM_REQ must be 2..16 and PRIO0_BURST >= 1");
  end

  logic                r_out_vld;
  logic [DATA_W-1:0]   r_out_data;
  logic [ID_W-1:0]     r_out_id;
  logic [STALL_W-1:0]  r_stall;
  logic [ID_W-1:0]     r_ptr;

  logic                w_accept;
  logic                w_any;
  logic                w_grant;
  logic [NUM_REQ-1:0]  w_cand;
  logic                w_force0;
  logic [ID_W-1:0]     w_rr_win;
  logic                w_rr_found;
  logic [ID_W-1:0]     w_win;
  logic                w_win_is0;

  // The register can take a new entry when empty or when it drains this cycle.
  assign w_accept  = !r_out_vld || out_rdy;
  assign w_any     = |req_vld;
  // No grant is issued while reset is held.
  assign w_grant   = rst_n && w_accept && w_any;
  assign w_win_is0 = (w_win == '0);

`ifdef TT_DFD_CAPTURE_ARB_PRIO0_EN
  localparam int BURST_W = (PRIO0_BURST > 0) ? $clog2(PRIO0_BURST + 1) : 1;

  logic [BURST_W-1:0] r_burst;
  logic               w_contested;
  logic               w_burst_full;

  assign w_contested  = req_vld[0] && (|req_vld[NUM_REQ-1:1]);
  assign w_burst_full = (r_burst >= BURST_W'(PRIO0_BURST));
  // Requester 0 wins outright until its contested burst budget is used up;
  // then one round-robin search runs with requester 0 masked out.
  assign w_force0     = req_vld[0] && !w_burst_full;
  assign w_cand       = w_burst_full ? (req_vld & ~NUM_REQ'(1)) : req_vld;

  // Count consecutive contested requester-0 wins; any other winner resets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else if (w_grant) begin
      if (!w_win_is0) begin
        r_burst <= '0;
      end else if (w_contested && !w_burst_full) begin
        r_burst <= r_burst + BURST_W'(1);
      end
    end
  end
`else
  assign w_force0 = 1'b0;
  assign w_cand   = req_vld;
`endif

  // Round-robin search over the candidates, starting just after the pointer.
  always_comb begin
    w_rr_win   = '0;
    w_rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_rr_found && w_cand[idx]) begin
        w_rr_found = 1'b1;
        w_rr_win   = ID_W'(idx);
      end
    end
  end

  // Final winner: forced requester 0, else round-robin result. If the masked
  // search finds nobody, requester 0 is the only valid source and takes it.
  always_comb begin
    w_win = '0;
    if (!w_force0 && w_rr_found) begin
      w_win = w_rr_win;
    end
  end

  // One-hot grant back to the winning requester.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = w_grant && (w_win == ID_W'(i));
    end
  end

  // Round-robin pointer follows the last winner (non-0 winners only when
  // requester 0 has priority, so its wins do not disturb the rotation).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
`ifdef TT_DFD_CAPTURE_ARB_PRIO0_EN
    end else if (w_grant && !w_win_is0) begin
`else
    end else if (w_grant) begin
`endif
      r_ptr <= w_win;
    end
  end

  // Holding register: load on grant, empty on drain without reload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else if (w_grant) begin
      r_out_vld  <= 1'b1;
      r_out_data <= req_data[int'(w_win)*DATA_W +: DATA_W];
      r_out_id   <= w_win;
    end else if (r_out_vld && out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  // Saturating count of consecutive back-pressured cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (r_out_vld && !out_rdy) begin
      if (!(&r_stall)) begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end else begin
      r_stall <= '0;
    end
  end

  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign stall_cnt = r_stall;
  assign busy      = r_out_vld || w_any;

endmodule

// File: doc/tt_dfd_capture_arb.md
Name: tt_dfd_capture_arb

Overview:
- Round-robin arbiter and sequencer for a single shared debug capture register.
- NUM_REQ debug sources (trace taps, event monitors) compete to load their payload into one output holding register. The register is drained by a downstream valid/ready consumer, such as a trace funnel or debug bus bridge.
- Sequences the register enable, tags each entry with the source id, and reports back-pressure stall duration.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, payload width per requester.
- STALL_W, 16, width of the saturating stall counter.
- PRIO0_BURST, 4, maximum consecutive requester-0 wins before one forced round-robin grant; used only with the optional feature.
- ID_W is a localparam: max(1, $clog2(NUM_REQ)).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- req_vld  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_rdy  output  NUM_REQ  one-hot grant; transfer when req_vld[i] && req_rdy[i].
- out_vld  output  1  holding register full.
- out_data  output  DATA_W  held payload.
- out_id  output  ID_W  index of the requester that loaded the held payload.
- out_rdy  input  1  downstream accept.
- stall_cnt  output  STALL_W  consecutive cycles with out_vld && !out_rdy.
- busy  output  1  out_vld || (|req_vld).

Behaviour:
- Reset values: out_vld=0, out_data=0, out_id=0, stall_cnt=0. The round-robin pointer resets to NUM_REQ-1, so the first search starts at requester 0. The burst counter resets to 0.
- accept = !out_vld || out_rdy. This is a full-throughput single-entry register: it can drain and reload in the same cycle.
- Grant search is combinational. Search starts at ptr+1 mod NUM_REQ and wraps. The first requester with req_vld set wins.
- req_rdy[win] = accept && |req_vld. All other req_rdy bits are 0. req_rdy never depends on out_vld being 1 when out_rdy is 1.
- On a grant, at the next edge: out_data <= req_data[win], out_id <= win, out_vld <= 1, ptr <= win.
  - Latency is 1 cycle from handshake to out_vld.
- On out_vld && out_rdy with no grant: out_vld <= 0. out_data and out_id hold their last values.
- With out_vld && !out_rdy:
  - all req_rdy = 0;
  - out_data and out_id are frozen;
  - stall_cnt increments and saturates at all-ones.
- stall_cnt clears to 0 on the cycle after any out handshake, and whenever out_vld=0.
- ptr is unchanged when no grant occurs. A requester that drops req_vld without a handshake is simply skipped.
- Requesters hold req_vld and req_data stable until granted. The block does not check this.
- If only one requester is active, it is granted on every accept cycle: 100% throughput.
- Reset asserted mid-transfer discards the held entry. out_vld=0 on the cycle after reset is sampled low. No grant is issued while rst_n=0.

Optional Feature:
- Macro: TT_DFD_CAPTURE_ARB_PRIO0_EN.
- Defined: requester 0 is high priority.
  - If req_vld[0], requester 0 wins regardless of ptr.
  - Exception: requester 0 has won PRIO0_BURST consecutive grants while another requester was also valid. In that case the next grant uses the normal round-robin search with requester 0 excluded.
  - The burst counter increments on each contested requester-0 grant and clears on any non-0 grant.
  - ptr updates only on non-0 grants.
- Undefined: pure round-robin as above. The burst counter logic is absent.

Test Plan:
- Reset, then req_vld=4'b1111 with out_rdy=1 held -> grants in order 0,1,2,3,0. out_vld=1 from cycle 2. out_id sequence 0,1,2,3.
- Single requester 2 valid continuously, out_rdy=1 -> req_rdy=4'b0100 every cycle. One entry per cycle. out_data tracks req_data[2] with 1-cycle latency.
- Entry loaded, out_rdy=0 for 20 cycles -> req_rdy=0, out_data frozen, stall_cnt reaches 20. It clears to 0 the cycle after out_rdy=1. Repeat with STALL_W=4 -> saturates at 15.
- Requester 1 granted, then req_vld=4'b1001 -> next grant is 3, not 0. Then requester 0.
- Assert rst_n=0 while out_vld=1 -> out_vld=0, out_id=0, stall_cnt=0. After release, the first grant goes to the lowest-index valid requester.
- With TT_DFD_CAPTURE_ARB_PRIO0_EN and PRIO0_BURST=4, req_vld=4'b0011 constant, out_rdy=1 -> grant pattern 0,0,0,0,1,0,0,0,0,1.
